csr_exec_unit: RTL and testbench
================================

# csr_exec_unit

Sequencer that executes Zicsr instructions against the machine-mode CSR file. It accepts one decoded CSR instruction at a time over a valid/ready handshake and issues the CSR read address. It computes the new CSR value per funct3, then drives the CSR file's write port, the integer-register writeback and the retired-instruction pulse. It sits between decode/EXE and the `csr` register file, acting as that file's sole reader and writer.

## Interface
- `DATA_WIDTH`, 32, CSR and GPR data width
- `CSR_ADDR_WIDTH`, 12, CSR address width
- `clk_i  in  1  clock; single clock domain`
- `rst_i  in  1  synchronous, active-high reset`
- `valid_i  in  1  instruction offer`
- `ready_o  out  1  unit can accept; high only in IDLE`
- `funct3_i  in  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI`
- `csr_addr_i  in  CSR_ADDR_WIDTH  target CSR`
- `rs1_addr_i  in  5  rs1 index; for imm forms, the zimm field`
- `rs1_data_i  in  DATA_WIDTH  rs1 value (ignored for imm forms)`
- `rd_addr_i  in  5  destination GPR`
- `csr_raddr_o  out  CSR_ADDR_WIDTH  to CSR file read port`
- `csr_rdata_i  in  DATA_WIDTH  from CSR file, combinational`
- `csr_we_o  out  1  CSR write enable`
- `csr_waddr_o  out  CSR_ADDR_WIDTH  CSR write address`
- `csr_wdata_o  out  DATA_WIDTH  CSR write data`
- `instret_incr_o  out  1  one-cycle retire pulse`
- `rd_we_o  out  1  GPR write enable`
- `rd_addr_o  out  5  GPR index`
- `rd_wdata_o  out  DATA_WIDTH  old CSR value`
- `done_o  out  1  one-cycle completion pulse`
- `illegal_o  out  1  one-cycle illegal-instruction pulse, coincident with done_o`

## Operation
- FSM states: IDLE, READ, COMMIT.
- IDLE: `ready_o`=1. When `valid_i` is high, latch funct3, csr_addr, rs1_addr, rs1_data and rd_addr, then go to READ.
- READ: `csr_raddr_o` = latched address. Capture `csr_rdata_i` into old_q. Compute new_q. Go to COMMIT.
- Operand: if funct3[2]=1, the operand is zero-extended rs1_addr (zimm); otherwise it is rs1_data.
- New value: RW gives op. RS gives old | op. RC gives old & ~op.
- Write suppression: RS/RC/RSI/RCI with rs1_addr==0 perform no CSR write. RW/RWI always write.
- COMMIT, exactly one cycle:
  - `csr_we_o`=write_q, `csr_waddr_o`=addr, `csr_wdata_o`=new_q.
  - `rd_we_o`=(rd_addr!=0), `rd_wdata_o`=old_q.
  - `instret_incr_o`=1, `done_o`=1.
  - Return to IDLE.
- Illegal funct3 (000, 100): COMMIT asserts `illegal_o`=1 and `done_o`=1. `csr_we_o`, `rd_we_o` and `instret_incr_o` stay 0.
- Outputs are registered or decoded from state. All strobes are 0 outside COMMIT. `csr_raddr_o` holds the latched address outside READ.

## Timing
- Reset values:
  - state=IDLE, so `ready_o`=1.
  - All strobes 0.
  - `csr_raddr_o`, `csr_waddr_o`, `csr_wdata_o`, `rd_addr_o`, `rd_wdata_o` = 0.
- Latency: accept at cycle N, READ at N+1, COMMIT at N+2. `ready_o` is high again at N+3.
- Throughput is one instruction per 3 cycles. Back-to-back `valid_i` is accepted at N+3.
- `csr_we_o` is never high in READ, so the CSR file's write-to-read bypass never affects the captured old value.
- Reset asserted in READ or COMMIT aborts the instruction: no CSR write and no retire pulse on the following cycle. The unit is in IDLE on the first cycle after reset deasserts.
- `valid_i` while not ready is ignored, with no buffering. The upstream stage holds the instruction.

## Configuration
- `CSR_RO_CHECK_EN`, when defined: an instruction that would write a CSR with addr[11:10]==2'b11 (read-only space) is illegal.
  - COMMIT gives `illegal_o`=1 and `done_o`=1, with no CSR write, no rd write and no retire.
  - Read-only accesses that do not write (RS/RC with rs1=0) remain legal.
- When undefined: no check. The write is issued and the CSR file drops it.

## Structure
- The shared `defines.v` holds:
  - funct3 encodings (`CSR_OP_RW` … `CSR_OP_RCI`)
  - `CSR_ADDR_WIDTH` and `DATA_WIDTH`
  - FSM state encodings
- Sub-module `csr_alu` is combinational. Inputs are funct3, old, op and rs1_addr. Outputs are new value, write flag and illegal flag.

## Test plan
- CSRRW mscratch (0x340): rs1=x5=0xDEADBEEF, rd=x6, mscratch=0 → COMMIT at N+2 with csr_we=1, wdata=0xDEADBEEF, rd_we=1, rd_wdata=0, instret_incr=1.
- CSRRS mstatus (0x300): old 0x8, rs1 data 0x80 → wdata 0x88. Then CSRRC with 0x8 → wdata 0x80.
- CSRRSI rs1_addr=0, rd=x1, on mcycle (0xB00) → csr_we=0, rd_we=1, rd_wdata=current mcycle low word, retire=1.
- CSRRWI mtvec zimm=0x1F, rd=x0 → csr_wdata=0x1F, rd_we=0. Back-to-back second op accepted exactly 3 cycles after the first.
- funct3=100 → illegal_o=1, done_o=1, no writes, no retire. With `CSR_RO_CHECK_EN`, CSRRW to mvendorid (0xF11) → illegal_o=1, and CSRRS 0xF11 with rs1=0 → legal, rd_wdata=0.
- Reset asserted in READ → no csr_we/instret_incr afterwards, ready_o=1 on the first cycle after reset release.

Source files
------------

// File: rtl/csr_exec_unit_pkg.sv
// ============================================================================
// Module  : csr_exec_unit_pkg
// Brief   : Shared widths, Zicsr funct3 encodings and sequencer state encoding.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package csr_exec_unit_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_CSR_ADDR_WIDTH = 12;

  localparam logic [2:0] CSR_OP_RW  = 3'b001;
  localparam logic [2:0] CSR_OP_RS  = 3'b010;
  localparam logic [2:0] CSR_OP_RC  = 3'b011;
  localparam logic [2:0] CSR_OP_RWI = 3'b101;
  localparam logic [2:0] CSR_OP_RSI = 3'b110;
  localparam logic [2:0] CSR_OP_RCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/csr_alu.sv
// ============================================================================
// Module  : csr_alu
// Brief   : Combinational new-value, write-enable and illegal decode for Zicsr.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_alu
  import csr_exec_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] old_val,
  input  logic [DATA_WIDTH-1:0] op_val,
  input  logic [4:0]            rs1_addr,
  output logic [DATA_WIDTH-1:0] new_val,
  output logic                  write,
  output logic                  illegal
);

  logic w_rs1_nz;
  assign w_rs1_nz = (rs1_addr != 5'd0);

  always_comb begin
    new_val = old_val;
    write   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      CSR_OP_RW, CSR_OP_RWI: begin
        new_val = op_val;
        write   = 1'b1;
      end
      // Set/clear forms with x0 / zimm=0 are pure reads and must not write.
      CSR_OP_RS, CSR_OP_RSI: begin
        new_val = old_val | op_val;
        write   = w_rs1_nz;
      end
      CSR_OP_RC, CSR_OP_RCI: begin
        new_val = old_val & ~op_val;
        write   = w_rs1_nz;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/csr_exec_unit.sv
// ============================================================================
// Module  : csr_exec_unit
// Brief   : IDLE/READ/COMMIT sequencer executing one Zicsr instruction at a
//           time against the machine-mode CSR file. Optional macro
//           CSR_RO_CHECK_EN flags writes to the read-only CSR space as illegal.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_exec_unit
  import csr_exec_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int CSR_ADDR_WIDTH = DEF_CSR_ADDR_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [2:0]                funct3_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
  input  logic [4:0]                rs1_addr_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [4:0]                rd_addr_i,
  output logic [CSR_ADDR_WIDTH-1:0] csr_raddr_o,
  input  logic [DATA_WIDTH-1:0]     csr_rdata_i,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      instret_incr_o,
  output logic                      rd_we_o,
  output logic [4:0]                rd_addr_o,
  output logic [DATA_WIDTH-1:0]     rd_wdata_o,
  output logic                      done_o,
  output logic                      illegal_o
);

  state_t                    r_state, w_next;
  logic [2:0]                r_funct3;
  logic [CSR_ADDR_WIDTH-1:0] r_addr;
  logic [4:0]                r_rs1_addr;
  logic [DATA_WIDTH-1:0]     r_rs1_data;
  logic [4:0]                r_rd_addr;
  logic [DATA_WIDTH-1:0]     r_old, r_new;
  logic                      r_write, r_illegal;

  logic [DATA_WIDTH-1:0]     w_op, w_new;
  logic                      w_alu_write, w_alu_illegal, w_ro_violation, w_illegal;
  logic                      w_commit;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (valid_i) w_next = ST_READ;
      ST_READ:   w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign w_op = r_funct3[2] ? {{(DATA_WIDTH-5){1'b0}}, r_rs1_addr} : r_rs1_data;

  csr_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .funct3   (r_funct3),
    .old_val  (csr_rdata_i),
    .op_val   (w_op),
    .rs1_addr (r_rs1_addr),
    .new_val  (w_new),
    .write    (w_alu_write),
    .illegal  (w_alu_illegal)
  );

`ifdef CSR_RO_CHECK_EN
  // Only instructions that actually write are rejected; pure reads stay legal.
  assign w_ro_violation = w_alu_write && (r_addr[CSR_ADDR_WIDTH-1 -: 2] == 2'b11);
`else
  assign w_ro_violation = 1'b0;
`endif

  assign w_illegal = w_alu_illegal | w_ro_violation;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_funct3   <= 3'd0;
      r_addr     <= '0;
      r_rs1_addr <= 5'd0;
      r_rs1_data <= '0;
      r_rd_addr  <= 5'd0;
      r_old      <= '0;
      r_new      <= '0;
      r_write    <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && valid_i) begin
        r_funct3   <= funct3_i;
        r_addr     <= csr_addr_i;
        r_rs1_addr <= rs1_addr_i;
        r_rs1_data <= rs1_data_i;
        r_rd_addr  <= rd_addr_i;
      end
      if (r_state == ST_READ) begin
        r_old     <= csr_rdata_i;
        r_new     <= w_new;
        r_write   <= w_alu_write & ~w_illegal;
        r_illegal <= w_illegal;
      end
    end
  end

  assign w_commit       = (r_state == ST_COMMIT);
  assign ready_o        = (r_state == ST_IDLE);
  assign csr_raddr_o    = r_addr;
  assign csr_waddr_o    = r_addr;
  assign csr_wdata_o    = r_new;
  assign csr_we_o       = w_commit & r_write;
  assign rd_addr_o      = r_rd_addr;
  assign rd_wdata_o     = r_old;
  assign rd_we_o        = w_commit & ~r_illegal & (r_rd_addr != 5'd0);
  assign instret_incr_o = w_commit & ~r_illegal;
  assign done_o         = w_commit;
  assign illegal_o      = w_commit & r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_csr_exec_unit.sv
// ============================================================================
// Module  : tb_csr_exec_unit
// Brief   : Vector-table and scoreboard bench for csr_exec_unit with a CSR file model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_csr_exec_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  funct3_i;
  logic [11:0] csr_addr_i;
  logic [4:0]  rs1_addr_i;
  logic [31:0] rs1_data_i;
  logic [4:0]  rd_addr_i;
  logic [11:0] csr_raddr_o;
  logic [31:0] csr_rdata_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        instret_incr_o;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o;
  logic        done_o;
  logic        illegal_o;

  always #5 clk = ~clk;

  csr_exec_unit dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .funct3_i       (funct3_i),
    .csr_addr_i     (csr_addr_i),
    .rs1_addr_i     (rs1_addr_i),
    .rs1_data_i     (rs1_data_i),
    .rd_addr_i      (rd_addr_i),
    .csr_raddr_o    (csr_raddr_o),
    .csr_rdata_i    (csr_rdata_i),
    .csr_we_o       (csr_we_o),
    .csr_waddr_o    (csr_waddr_o),
    .csr_wdata_o    (csr_wdata_o),
    .instret_incr_o (instret_incr_o),
    .rd_we_o        (rd_we_o),
    .rd_addr_o      (rd_addr_o),
    .rd_wdata_o     (rd_wdata_o),
    .done_o         (done_o),
    .illegal_o      (illegal_o)
  );

  // CSR file model: combinational read, registered write, preloaded once.
  logic [31:0] csr_mem [0:4095];
  logic        mem_loaded = 1'b0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'h0;
      csr_mem[12'h300] <= 32'h0000_0008;
      csr_mem[12'h305] <= 32'hAAAA_0000;
      csr_mem[12'h341] <= 32'h0000_0100;
      csr_mem[12'h342] <= 32'h0000_0007;
      csr_mem[12'hB00] <= 32'h1234_5678;
      mem_loaded <= 1'b1;
    end else if (csr_we_o) begin
      csr_mem[csr_waddr_o] <= csr_wdata_o;
    end
  end

  always_comb csr_rdata_i = csr_mem[csr_raddr_o];

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  rs1;
    logic [31:0] rs1d;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wdata;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic        ill;
  } vec_t;

  vec_t vecs [12];
  vec_t sb [$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [2:0] f3, input logic [11:0] addr,
                              input logic [4:0] rs1, input logic [31:0] rs1d,
                              input logic [4:0] rd, input logic we,
                              input logic [31:0] wdata, input logic rd_we,
                              input logic [31:0] rd_wdata, input logic ill);
    vec_t v;
    v.f3 = f3; v.addr = addr; v.rs1 = rs1; v.rs1d = rs1d; v.rd = rd;
    v.we = we; v.wdata = wdata; v.rd_we = rd_we; v.rd_wdata = rd_wdata; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    funct3_i   = v.f3;
    csr_addr_i = v.addr;
    rs1_addr_i = v.rs1;
    rs1_data_i = v.rs1d;
    rd_addr_i  = v.rd;
  endtask

  task automatic check_commit();
    vec_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("done", done_o, 1'b1);
    chk("csr_we", csr_we_o, e.we);
    if (e.we) begin
      chk("csr_waddr", csr_waddr_o, e.addr);
      chk("csr_wdata", csr_wdata_o, e.wdata);
    end
    chk("rd_we", rd_we_o, e.rd_we);
    chk("rd_addr", rd_addr_o, e.rd);
    if (!e.ill) chk("rd_wdata", rd_wdata_o, e.rd_wdata);
    chk("instret", instret_incr_o, !e.ill);
    chk("illegal", illegal_o, e.ill);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    while (!ready_o && n < 10) begin tick(); n++; end
    chk("ready_before", ready_o, 1'b1);
    drive(v);
    valid_i = 1'b1;
    sb.push_back(v);
    tick();
    valid_i = 1'b0;
    chk("ready_in_read", ready_o, 1'b0);
    chk("we_in_read", csr_we_o, 1'b0);
    n = 0;
    while (!done_o && n < 5) begin tick(); n++; end
    chk("latency", n, 1);
    check_commit();
    tick();
    chk("ready_after", ready_o, 1'b1);
    chk("done_after", done_o, 1'b0);
  endtask

  initial begin
    vec_t a, b;
    logic [31:0] saved;

    vecs[0]  = mk(3'b001, 12'h340, 5'd5, 32'hDEADBEEF, 5'd6, 1, 32'hDEADBEEF, 1, 32'h0, 0);
    vecs[1]  = mk(3'b010, 12'h300, 5'd7, 32'h80,       5'd8, 1, 32'h88,       1, 32'h8, 0);
    vecs[2]  = mk(3'b011, 12'h300, 5'd9, 32'h8,        5'd10, 1, 32'h80,      1, 32'h88, 0);
    vecs[3]  = mk(3'b110, 12'hB00, 5'd0, 32'hFFFFFFFF, 5'd1, 0, 32'h0,        1, 32'h12345678, 0);
    vecs[4]  = mk(3'b101, 12'h305, 5'h1F, 32'hFFFFFFFF, 5'd0, 1, 32'h1F,      0, 32'hAAAA0000, 0);
    vecs[5]  = mk(3'b100, 12'h340, 5'd3, 32'h1234,     5'd4, 0, 32'h0,        0, 32'h0, 1);
    vecs[6]  = mk(3'b000, 12'h340, 5'd3, 32'h1234,     5'd4, 0, 32'h0,        0, 32'h0, 1);
    vecs[7]  = mk(3'b111, 12'h340, 5'h0F, 32'h0,       5'd2, 1, 32'hDEADBEE0, 1, 32'hDEADBEEF, 0);
    vecs[8]  = mk(3'b110, 12'h340, 5'h10, 32'h0,       5'd2, 1, 32'hDEADBEF0, 1, 32'hDEADBEE0, 0);
    vecs[9]  = mk(3'b011, 12'h340, 5'd0, 32'hFFFFFFFF, 5'd3, 0, 32'h0,        1, 32'hDEADBEF0, 0);
    vecs[10] = mk(3'b010, 12'hF11, 5'd0, 32'hFFFFFFFF, 5'd5, 0, 32'h0,        1, 32'h0, 0);
`ifdef CSR_RO_CHECK_EN
    vecs[11] = mk(3'b001, 12'hF11, 5'd6, 32'h55,       5'd7, 0, 32'h0,        0, 32'h0, 1);
`else
    vecs[11] = mk(3'b001, 12'hF11, 5'd6, 32'h55,       5'd7, 1, 32'h55,       1, 32'h0, 0);
`endif

    rst_i = 1'b1; valid_i = 1'b0;
    drive(vecs[0]);
    repeat (3) tick();
    rst_i = 1'b0;
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_strobes", {csr_we_o, rd_we_o, instret_incr_o, done_o, illegal_o}, 5'b0);
    chk("rst_raddr", csr_raddr_o, 12'h0);
    chk("rst_waddr", csr_waddr_o, 12'h0);
    chk("rst_wdata", csr_wdata_o, 32'h0);
    chk("rst_rd_addr", rd_addr_o, 5'h0);
    chk("rst_rd_wdata", rd_wdata_o, 32'h0);

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i]);
      if (i == 0) chk("mem_mscratch", csr_mem[12'h340], 32'hDEADBEEF);
    end

    // Reset during READ aborts the instruction with no write or retire.
    saved = csr_mem[12'h342];
    a = mk(3'b001, 12'h342, 5'd1, 32'h11111111, 5'd2, 1, 32'h11111111, 1, 32'h7, 0);
    drive(a);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("abort_ready", ready_o, 1'b1);
    chk("abort_we", csr_we_o, 1'b0);
    chk("abort_instret", instret_incr_o, 1'b0);
    chk("abort_done", done_o, 1'b0);
    tick();
    chk("abort_done2", done_o, 1'b0);
    chk("abort_mem", csr_mem[12'h342], saved);

    // Back-to-back: valid held high, changed inputs while busy must be ignored.
    a = mk(3'b101, 12'h341, 5'd3, 32'h0,  5'd9,  1, 32'h3,  1, 32'h100, 0);
    b = mk(3'b010, 12'h341, 5'd4, 32'h30, 5'd10, 1, 32'h33, 1, 32'h3,   0);
    drive(a);
    valid_i = 1'b1;
    sb.push_back(a);
    tick();
    drive(b);
    chk("b2b_busy_read", ready_o, 1'b0);
    tick();
    chk("b2b_busy_commit", ready_o, 1'b0);
    check_commit();
    tick();
    chk("b2b_ready_n3", ready_o, 1'b1);
    sb.push_back(b);
    tick();
    valid_i = 1'b0;
    chk("b2b_accepted", ready_o, 1'b0);
    tick();
    check_commit();
    tick();

    run_vec(vecs[11]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
